// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART command controller.
// Holds the controller state encoding, the framing/response byte values and
// a saturating increment helper used by the error counter.
package uart_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE,
    GET_CMD,
    GET_ADDR,
    GET_DATA,
    GET_CHK,
    EXEC,
    TX_ACK,
    TX_VAL,
    TX_WAIT
  } state_t;

  localparam logic [7:0] SYNC   = 8'hA5;
  localparam logic [7:0] CMD_WR = 8'h01;
  localparam logic [7:0] CMD_RD = 8'h02;
  localparam logic [7:0] ACK    = 8'h06;
  localparam logic [7:0] NAK    = 8'h15;

  function automatic logic [7:0] sat_inc(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/uart_ctrl_regfile.sv
// NREG x 8-bit register file with a single write port and a flattened
// read-out bus.
// Ports:
//   clk, rst_n  - system clock, asynchronous active-low reset
//   we          - write enable
//   waddr       - write address
//   wdata       - write data
//   regs        - all registers, reg i at bits [8i+7:8i]
module uart_ctrl_regfile
  import uart_ctrl_pkg::*;
#(
  parameter int NREG = 8,
  parameter int AW   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [7:0]        wdata,
  output logic [8*NREG-1:0] regs
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '0;
    end else if (we) begin
      regs[{waddr, 3'b000} +: 8] <= wdata;
    end
  end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// UART command controller.
// Parses SYNC/CMD/ADDR/DATA/CHK frames from a UART receiver, executes
// register writes and reads, and answers through a UART transmitter with
// ACK (plus the register value for reads) or NAK.
// Ports:
//   clk, rst_n  - system clock, asynchronous active-low reset
//   baud_en     - baud tick strobe, used for inter-byte timeout only
//   rx_data     - received byte
//   data_valid  - receiver valid level; its rising edge marks one byte
//   tx_busy     - transmitter busy
//   tx_data     - byte to transmit
//   tx_start    - one-cycle transmit request
//   reg_out     - flattened register file
//   err_cnt     - saturating count of rejected/aborted frames
module uart_cmd_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int TIMEOUT_TICKS = 32,
  parameter int NREG          = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              baud_en,
  input  logic [7:0]        rx_data,
  input  logic              data_valid,
  input  logic              tx_busy,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  output logic [8*NREG-1:0] reg_out,
  output logic [7:0]        err_cnt
);

  localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [8:0]    NREG_LIM  = 9'(NREG);
  localparam logic [TW-1:0] TICK_LAST = TW'(TIMEOUT_TICKS - 1);

  state_t        state, state_nx;
  logic          dv_q;
  logic          accept;
  logic [7:0]    cmd_q, addr_q, data_q, chk_q;
  logic [TW-1:0] tick_cnt, tick_nx;
  logic          hold_q, hold_nx;
  logic          rd_pend_q, rd_pend_nx;
  logic [7:0]    tx_data_nx;
  logic [7:0]    rd_byte;
  logic          err_inc;
  logic          we;
  logic          frame_ok;

  // A held-high data_valid is a single byte, so only its rising edge counts.
  assign accept = data_valid & ~dv_q;

  assign frame_ok = (chk_q == (cmd_q ^ addr_q ^ data_q)) &&
                    ((cmd_q == CMD_WR) || (cmd_q == CMD_RD)) &&
                    ({1'b0, addr_q} < NREG_LIM);

  assign rd_byte = reg_out[{addr_q[AW-1:0], 3'b000} +: 8];

  uart_ctrl_regfile #(
    .NREG (NREG),
    .AW   (AW)
  ) u_regfile (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .waddr (addr_q[AW-1:0]),
    .wdata (data_q),
    .regs  (reg_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      dv_q      <= 1'b0;
      tick_cnt  <= '0;
      hold_q    <= 1'b0;
      rd_pend_q <= 1'b0;
      tx_data   <= 8'h00;
      err_cnt   <= 8'h00;
    end else begin
      state     <= state_nx;
      dv_q      <= data_valid;
      tick_cnt  <= tick_nx;
      hold_q    <= hold_nx;
      rd_pend_q <= rd_pend_nx;
      tx_data   <= tx_data_nx;
      if (err_inc) begin
        err_cnt <= sat_inc(err_cnt);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q  <= 8'h00;
      addr_q <= 8'h00;
      data_q <= 8'h00;
      chk_q  <= 8'h00;
    end else if (accept) begin
      case (state)
        GET_CMD:  cmd_q  <= rx_data;
        GET_ADDR: addr_q <= rx_data;
        GET_DATA: data_q <= rx_data;
        GET_CHK:  chk_q  <= rx_data;
        default:  ;
      endcase
    end
  end

  // tx_data is loaded before each pulse and then left alone, so it stays
  // stable for the transmitter until the next byte is queued. hold_q masks
  // tx_busy for the cycle right after a pulse, before the transmitter has
  // had a chance to raise it.
  always_comb begin
    state_nx   = state;
    tick_nx    = tick_cnt;
    hold_nx    = 1'b0;
    rd_pend_nx = rd_pend_q;
    tx_data_nx = tx_data;
    tx_start   = 1'b0;
    err_inc    = 1'b0;
    we         = 1'b0;
    case (state)
      IDLE: begin
        tick_nx    = '0;
        rd_pend_nx = 1'b0;
        if (accept && (rx_data == SYNC)) begin
          state_nx = GET_CMD;
        end
      end
      GET_CMD, GET_ADDR, GET_DATA, GET_CHK: begin
        // An accepted byte takes priority over a timeout in the same cycle.
        if (accept) begin
          tick_nx = '0;
          case (state)
            GET_CMD:  state_nx = GET_ADDR;
            GET_ADDR: state_nx = GET_DATA;
            GET_DATA: state_nx = GET_CHK;
            default:  state_nx = EXEC;
          endcase
        end else if (baud_en) begin
          if (tick_cnt == TICK_LAST) begin
            state_nx = IDLE;
            tick_nx  = '0;
            err_inc  = 1'b1;
          end else begin
            tick_nx = tick_cnt + 1'b1;
          end
        end
      end
      EXEC: begin
        tick_nx  = '0;
        state_nx = TX_ACK;
        if (frame_ok) begin
          tx_data_nx = ACK;
          we         = (cmd_q == CMD_WR);
          rd_pend_nx = (cmd_q == CMD_RD);
        end else begin
          tx_data_nx = NAK;
          rd_pend_nx = 1'b0;
          err_inc    = 1'b1;
        end
      end
      TX_ACK: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          hold_nx  = 1'b1;
          state_nx = TX_WAIT;
        end
      end
      TX_VAL: begin
        if (!tx_busy) begin
          tx_start   = 1'b1;
          hold_nx    = 1'b1;
          rd_pend_nx = 1'b0;
          state_nx   = TX_WAIT;
        end
      end
      TX_WAIT: begin
        if (!hold_q && !tx_busy) begin
          if (rd_pend_q) begin
            tx_data_nx = rd_byte;
            state_nx   = TX_VAL;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl.
// A byte-level model tracks frames, registers, error count and the queue of
// response bytes; a monitor process emulates the UART transmitter and checks
// every tx_start pulse against that queue. Directed scenarios add literal
// expectations on top of the model.
module tb_uart_cmd_ctrl;

  localparam int NREG  = 8;
  localparam int TO    = 32;
  localparam int TXLEN = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               baud_en;
  logic [7:0]         rx_data;
  logic               data_valid;
  logic               force_busy;
  logic               busy_int;
  logic               tx_busy;
  logic [7:0]         tx_data;
  logic               tx_start;
  logic [8*NREG-1:0]  reg_out;
  logic [7:0]         err_cnt;

  int checks   = 0;
  int failures = 0;

  logic [7:0] m_regs [NREG];
  logic [7:0] m_frame [4];
  int         m_err;
  int         m_phase;
  int         m_ticks;
  bit         m_resp;
  logic [7:0] exp_q[$];
  logic [7:0] tx_log[$];
  bit         pend;
  int         busy_cnt;
  bit         stab_valid;
  logic [7:0] last_sent;
  int         n0;

  assign tx_busy = force_busy | busy_int;

  always #10 clk = ~clk;

  uart_cmd_ctrl #(
    .TIMEOUT_TICKS (TO),
    .NREG          (NREG)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .baud_en    (baud_en),
    .rx_data    (rx_data),
    .data_valid (data_valid),
    .tx_busy    (tx_busy),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .reg_out    (reg_out),
    .err_cnt    (err_cnt)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NREG; i++) m_regs[i] = 8'h00;
    m_err   = 0;
    m_phase = 0;
    m_ticks = 0;
    m_resp  = 1'b0;
    exp_q.delete();
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    logic [7:0] c, a, d, k;
    logic ok;
    if (m_resp) return;
    if (m_phase == 0) begin
      if (b == 8'hA5) begin
        m_phase = 1;
        m_ticks = 0;
      end
    end else begin
      m_frame[m_phase-1] = b;
      m_ticks = 0;
      if (m_phase < 4) begin
        m_phase++;
      end else begin
        c  = m_frame[0];
        a  = m_frame[1];
        d  = m_frame[2];
        k  = m_frame[3];
        ok = (k == (c ^ a ^ d)) && (c == 8'h01 || c == 8'h02) && (int'(a) < NREG);
        if (ok) begin
          exp_q.push_back(8'h06);
          if (c == 8'h01) m_regs[a[2:0]] = d;
          else exp_q.push_back(m_regs[a[2:0]]);
        end else begin
          exp_q.push_back(8'h15);
          if (m_err < 255) m_err++;
        end
        m_phase = 0;
        m_resp  = 1'b1;
      end
    end
  endfunction

  function automatic void model_tick();
    if (m_phase != 0 && !m_resp) begin
      m_ticks++;
      if (m_ticks == TO) begin
        m_phase = 0;
        m_ticks = 0;
        if (m_err < 255) m_err++;
      end
    end
  endfunction

  function automatic logic [63:0] model_flat();
    logic [63:0] f;
    for (int i = 0; i < NREG; i++) f[i*8 +: 8] = m_regs[i];
    return f;
  endfunction

  function automatic logic [7:0] lastTx(input int back);
    if (tx_log.size() <= back) return 8'hXX;
    return tx_log[tx_log.size()-1-back];
  endfunction

  // Transmitter emulation and response monitor: busy rises the cycle after
  // a pulse and stays high for TXLEN cycles.
  initial begin
    busy_int   = 1'b0;
    pend       = 1'b0;
    busy_cnt   = 0;
    stab_valid = 1'b0;
    last_sent  = 8'h00;
    forever begin
      @(negedge clk);
      if (pend) begin
        busy_int = 1'b1;
        busy_cnt = TXLEN;
        pend     = 1'b0;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) busy_int = 1'b0;
      end
      #1;
      if (stab_valid && busy_int && rst_n) checkOutput("tx_stable", tx_data, last_sent);
      if (tx_start) begin
        checkOutput("tx_gate", tx_busy, 0);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL tx_unexpected actual=0x%0h expected=none", tx_data);
        end else begin
          checkOutput("tx_byte", tx_data, exp_q.pop_front());
        end
        tx_log.push_back(tx_data);
        last_sent  = tx_data;
        stab_valid = 1'b1;
        pend       = 1'b1;
      end
    end
  end

  task automatic sendByte(input logic [7:0] b, input int hold = 2);
    @(negedge clk);
    rx_data    = b;
    data_valid = 1'b1;
    model_byte(b);
    repeat (hold) @(negedge clk);
    data_valid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                               input logic [7:0] b3, input logic [7:0] b4);
    sendByte(b0);
    sendByte(b1);
    sendByte(b2);
    sendByte(b3);
    sendByte(b4);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      baud_en = 1'b1;
      model_tick();
      @(negedge clk);
      baud_en = 1'b0;
    end
  endtask

  task automatic waitResponse(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_drained"}, exp_q.size(), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    n = 0;
    while (tx_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    m_resp = 1'b0;
  endtask

  task automatic checkState(input string name);
    checkOutput({name, "_regs"}, reg_out, model_flat());
    checkOutput({name, "_err"}, err_cnt, m_err);
  endtask

  task automatic doReset(input string name);
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput({name, "_reg_out"}, reg_out, 0);
    checkOutput({name, "_err_cnt"}, err_cnt, 0);
    checkOutput({name, "_tx_start"}, tx_start, 0);
    checkOutput({name, "_tx_data"}, tx_data, 0);
    model_reset();
    stab_valid = 1'b0;
    data_valid = 1'b0;
    baud_en    = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n      = 1'b0;
    baud_en    = 1'b0;
    data_valid = 1'b0;
    rx_data    = 8'h00;
    force_busy = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    checkOutput("rst_reg_out", reg_out, 0);
    checkOutput("rst_err_cnt", err_cnt, 0);
    checkOutput("rst_tx_start", tx_start, 0);
    checkOutput("rst_tx_data", tx_data, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Write reg3 = 0x5C, with the first-pulse latency pinned
    sendByte(8'hA5);
    sendByte(8'h01);
    sendByte(8'h03);
    sendByte(8'h5C);
    @(negedge clk);
    rx_data    = 8'h5E;
    data_valid = 1'b1;
    model_byte(8'h5E);
    @(negedge clk);
    checkOutput("lat_exec_quiet", tx_start, 0);
    @(negedge clk);
    checkOutput("lat_first_start", tx_start, 1);
    checkOutput("lat_reg3", reg_out[31:24], 8'h5C);
    data_valid = 1'b0;
    waitResponse("wr1");
    checkState("wr1");
    checkOutput("wr1_ack", lastTx(0), 8'h06);

    // Read reg3 while the transmitter is held busy
    sendByte(8'hA5);
    sendByte(8'h02);
    sendByte(8'h03);
    sendByte(8'h00);
    force_busy = 1'b1;
    sendByte(8'h01);
    n0 = tx_log.size();
    repeat (10) @(negedge clk);
    checkOutput("rd_gated", tx_log.size(), n0);
    force_busy = 1'b0;
    waitResponse("rd1");
    checkOutput("rd1_ack", lastTx(1), 8'h06);
    checkOutput("rd1_val", lastTx(0), 8'h5C);
    checkState("rd1");

    // Rejected frames
    applyStimulus(8'hA5, 8'h01, 8'h03, 8'h5C, 8'h00);
    waitResponse("badchk");
    checkState("badchk");
    checkOutput("badchk_nak", lastTx(0), 8'h15);
    checkOutput("badchk_err", err_cnt, 1);
    applyStimulus(8'hA5, 8'h01, 8'h09, 8'h11, 8'h19);
    waitResponse("addr9");
    checkOutput("addr9_nak", lastTx(0), 8'h15);
    checkOutput("addr9_err", err_cnt, 2);
    applyStimulus(8'hA5, 8'h02, 8'h08, 8'h00, 8'h0A);
    waitResponse("addr8");
    checkOutput("addr8_nak", lastTx(0), 8'h15);
    applyStimulus(8'hA5, 8'h03, 8'h01, 8'h00, 8'h02);
    waitResponse("badcmd");
    checkOutput("badcmd_err", err_cnt, 4);
    applyStimulus(8'hA5, 8'h01, 8'h07, 8'hAA, 8'hAC);
    waitResponse("addr7");
    checkOutput("addr7_ack", lastTx(0), 8'h06);
    checkOutput("addr7_reg", reg_out[63:56], 8'hAA);
    checkState("bad_frames");

    // Non-sync bytes in IDLE are silently discarded
    n0 = tx_log.size();
    sendByte(8'h00);
    sendByte(8'h5A);
    repeat (5) @(negedge clk);
    checkOutput("idle_no_tx", tx_log.size(), n0);
    checkState("idle_junk");

    // Inter-byte timeout at exactly TO ticks
    sendByte(8'hA5);
    sendByte(8'h01);
    tick(31);
    repeat (2) @(negedge clk);
    checkOutput("to_31_err", err_cnt, 4);
    tick(1);
    repeat (2) @(negedge clk);
    checkOutput("to_32_err", err_cnt, 5);
    checkOutput("to_no_tx", tx_log.size(), n0);
    checkState("timeout");
    applyStimulus(8'hA5, 8'h01, 8'h01, 8'h11, 8'h11);
    waitResponse("after_to");
    checkState("after_to");

    // Byte arriving on the same cycle as the final tick wins
    sendByte(8'hA5);
    sendByte(8'h01);
    tick(31);
    @(negedge clk);
    rx_data    = 8'h03;
    data_valid = 1'b1;
    baud_en    = 1'b1;
    model_byte(8'h03);
    @(negedge clk);
    baud_en = 1'b0;
    @(negedge clk);
    data_valid = 1'b0;
    tick(31);
    sendByte(8'h77);
    sendByte(8'h75);
    waitResponse("race");
    checkState("race");
    checkOutput("race_err", err_cnt, 5);
    checkOutput("race_reg3", reg_out[31:24], 8'h77);

    // data_valid held high for 100 cycles is one byte
    sendByte(8'hA5, 100);
    sendByte(8'h01);
    sendByte(8'h02);
    sendByte(8'h33);
    sendByte(8'h30);
    waitResponse("held");
    checkOutput("held_reg2", reg_out[23:16], 8'h33);
    checkState("held");

    // Bytes arriving during a response are dropped
    force_busy = 1'b1;
    applyStimulus(8'hA5, 8'h01, 8'h04, 8'h44, 8'h41);
    sendByte(8'hA5);
    repeat (3) @(negedge clk);
    force_busy = 1'b0;
    waitResponse("drop_wr");
    applyStimulus(8'hA5, 8'h02, 8'h04, 8'h00, 8'h06);
    waitResponse("drop_rd");
    checkOutput("drop_rd_ack", lastTx(1), 8'h06);
    checkOutput("drop_rd_val", lastTx(0), 8'h44);
    checkState("drop");

    // Reset mid-frame, then a normal write
    sendByte(8'hA5);
    sendByte(8'h01);
    sendByte(8'h03);
    doReset("midframe");
    applyStimulus(8'hA5, 8'h01, 8'h03, 8'h5C, 8'h5E);
    waitResponse("post_rst");
    checkState("post_rst");
    checkOutput("post_rst_reg3", reg_out[31:24], 8'h5C);

    // Reset while a response is pending: nothing is sent afterwards
    force_busy = 1'b1;
    applyStimulus(8'hA5, 8'h02, 8'h03, 8'h00, 8'h01);
    doReset("midtx");
    force_busy = 1'b0;
    n0 = tx_log.size();
    repeat (20) @(negedge clk);
    checkOutput("midtx_no_tx", tx_log.size(), n0);

    // Error counter saturation
    for (int i = 0; i < 300; i++) begin
      applyStimulus(8'hA5, 8'h01, 8'h00, 8'h00, 8'hFF);
      waitResponse("sat");
    end
    checkOutput("sat_err", err_cnt, 255);
    checkState("sat");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] simulation did not finish");
  end

endmodule
